// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA raster scan counters with delayed sync/enable
//
// Purpose: divides clk down to a pixel tick, walks pixelX/pixelY over the full
// raster (active + porches + sync), and produces hsync/vsync/displayEnable
// delayed by PIPE_DELAY pixel ticks so they line up with drawing objects that
// register their pixel requests from the undelayed pixelX/pixelY.
//
// Ports:
//   clk           in   single clock
//   reset         in   synchronous, active-high
//   pixelX        out  horizontal count 0..H_TOTAL-1 (undelayed)
//   pixelY        out  vertical count 0..V_TOTAL-1 (undelayed)
//   pixelTick     out  one-clk strobe, pixel counters advance at its end
//   displayEnable out  active-area flag, delayed PIPE_DELAY ticks
//   hsync         out  active-low horizontal sync, delayed PIPE_DELAY ticks
//   vsync         out  active-low vertical sync, delayed PIPE_DELAY ticks
//   startOfFrame  out  one-clk pulse in the first clk at (0,0) after a wrap
module vga_scan_generator #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelTick,
  output logic        displayEnable,
  output logic        hsync,
  output logic        vsync,
  output logic        startOfFrame
);

  localparam logic [2:0]  DIV_LAST   = 3'(CLK_DIV - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [2:0]  r_div_cnt;
  logic [2:0]  w_div_next;
  logic        r_tick;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_sof;
  logic        w_x_last;
  logic        w_y_last;
  logic        w_de;
  logic        w_hs_n;
  logic        w_vs_n;
  logic        w_de_out;
  logic        w_hs_out;
  logic        w_vs_out;

  assign w_div_next = (r_div_cnt == DIV_LAST) ? 3'd0 : r_div_cnt + 3'd1;

  // The tick is registered from the same next-count as the divider so it is
  // high exactly while divCnt==CLK_DIV-1, yet still forced low by reset even
  // when CLK_DIV=1 (where divCnt is permanently 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= 3'd0;
      r_tick    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_tick    <= (w_div_next == DIV_LAST);
    end
  end

  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);

  // X and Y wrap in the same edge, so (H_LAST,V_LAST) goes straight to (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x   <= 11'd0;
      r_y   <= 11'd0;
      r_sof <= 1'b0;
    end else begin
      r_sof <= r_tick && w_x_last && w_y_last;
      if (r_tick) begin
        if (w_x_last) begin
          r_x <= 11'd0;
          r_y <= w_y_last ? 11'd0 : r_y + 11'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  assign w_de   = (r_x < H_ACT) && (r_y < V_ACT);
  assign w_hs_n = !((r_x >= H_SYNC_BEG) && (r_x <= H_SYNC_END));
  assign w_vs_n = !((r_y >= V_SYNC_BEG) && (r_y <= V_SYNC_END));

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign w_de_out = w_de;
      assign w_hs_out = w_hs_n;
      assign w_vs_out = w_vs_n;
    end else begin : g_delay
      // Each stage holds {de, hs_n, vs_n}; reset loads the blanked, idle-sync value.
      logic [2:0] r_pipe [PIPE_DELAY];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            r_pipe[i] <= 3'b011;
          end
        end else if (r_tick) begin
          r_pipe[0] <= {w_de, w_hs_n, w_vs_n};
          for (int i = 1; i < PIPE_DELAY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign {w_de_out, w_hs_out, w_vs_out} = r_pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign pixelX        = r_x;
  assign pixelY        = r_y;
  assign pixelTick     = r_tick;
  assign displayEnable = w_de_out;
  assign hsync         = w_hs_out;
  assign vsync         = w_vs_out;
  assign startOfFrame  = r_sof;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - scoreboard bench for vga_scan_generator
module tb_vga_scan_generator;

  typedef struct {
    int          cyc;
    logic [10:0] x;
    logic [10:0] y;
    logic [4:0]  f;  // {tick, de, hsync, vsync, sof}
  } exp_t;

  logic clk;
  logic reset_d;
  logic reset_s;
  int   cyc;
  int   checks;
  int   errors;
  int   base_d;
  int   base_s;
  exp_t q_d[$];
  exp_t q_s[$];
  exp_t e_mon;

  logic [10:0] d_x, d_y, s_x, s_y;
  logic d_tick, d_de, d_hs, d_vs, d_sof;
  logic s_tick, s_de, s_hs, s_vs, s_sof;

  // Default 640x480 timing.
  vga_scan_generator u_dflt (
    .clk          (clk),
    .reset        (reset_d),
    .pixelX       (d_x),
    .pixelY       (d_y),
    .pixelTick    (d_tick),
    .displayEnable(d_de),
    .hsync        (d_hs),
    .vsync        (d_vs),
    .startOfFrame (d_sof)
  );

  // Tiny raster, 16x8 total, undivided, no delay: whole frames in 128 clks.
  vga_scan_generator #(
    .CLK_DIV(1), .PIPE_DELAY(0),
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk          (clk),
    .reset        (reset_s),
    .pixelX       (s_x),
    .pixelY       (s_y),
    .pixelTick    (s_tick),
    .displayEnable(s_de),
    .hsync        (s_hs),
    .vsync        (s_vs),
    .startOfFrame (s_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", tag, act, req);
    end
  endtask

  task automatic cmp(input string inst, input exp_t e, input logic [10:0] x,
                     input logic [10:0] y, input logic [4:0] f);
    chk($sformatf("%s c%0d pixelX", inst, e.cyc), x, e.x);
    chk($sformatf("%s c%0d pixelY", inst, e.cyc), y, e.y);
    chk($sformatf("%s c%0d pixelTick", inst, e.cyc), 11'(f[4]), 11'(e.f[4]));
    chk($sformatf("%s c%0d displayEnable", inst, e.cyc), 11'(f[3]), 11'(e.f[3]));
    chk($sformatf("%s c%0d hsync", inst, e.cyc), 11'(f[2]), 11'(e.f[2]));
    chk($sformatf("%s c%0d vsync", inst, e.cyc), 11'(f[1]), 11'(e.f[1]));
    chk($sformatf("%s c%0d startOfFrame", inst, e.cyc), 11'(f[0]), 11'(e.f[0]));
  endtask

  // Monitor: samples on the falling edge, consumes every expectation due now.
  always @(negedge clk) begin
    while (q_d.size() > 0 && q_d[0].cyc <= cyc) begin
      e_mon = q_d.pop_front();
      if (e_mon.cyc < cyc) chk("dflt stale entry cycle", 11'(cyc), 11'(e_mon.cyc));
      else cmp("dflt", e_mon, d_x, d_y, {d_tick, d_de, d_hs, d_vs, d_sof});
    end
    while (q_s.size() > 0 && q_s[0].cyc <= cyc) begin
      e_mon = q_s.pop_front();
      if (e_mon.cyc < cyc) chk("small stale entry cycle", 11'(cyc), 11'(e_mon.cyc));
      else cmp("small", e_mon, s_x, s_y, {s_tick, s_de, s_hs, s_vs, s_sof});
    end
  end

  task automatic push_d(input int k, input int x, input int y, input logic [4:0] f);
    exp_t e;
    e.cyc = base_d + k; e.x = 11'(x); e.y = 11'(y); e.f = f;
    q_d.push_back(e);
  endtask

  task automatic push_s(input int k, input int x, input int y, input logic [4:0] f);
    exp_t e;
    e.cyc = base_s + k; e.x = 11'(x); e.y = 11'(y); e.f = f;
    q_s.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_d = 1'b1;
    reset_s = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Default instance: cycle base_d is the last clk sampled in reset.
    base_d  = cyc;
    reset_d = 1'b0;
    push_d(0,    0,   0, 5'b00110);
    push_d(1,    0,   0, 5'b10110);
    push_d(2,    1,   0, 5'b01110);
    push_d(1281, 640, 0, 5'b11110);
    push_d(1282, 641, 0, 5'b00110);
    push_d(1313, 656, 0, 5'b10110);
    push_d(1314, 657, 0, 5'b00010);
    push_d(1505, 752, 0, 5'b10010);
    push_d(1506, 753, 0, 5'b00110);
    push_d(1599, 799, 0, 5'b10110);
    push_d(1600, 0,   1, 5'b00110);
    push_d(1601, 0,   1, 5'b10110);
    push_d(1602, 1,   1, 5'b01110);
    push_d(2400, 400, 1, 5'b01110);
    wait_cyc(base_d + 2400);
    reset_d = 1'b1;
    @(posedge clk);
    #2;
    base_d  = cyc;
    reset_d = 1'b0;
    push_d(0, 0, 0, 5'b00110);
    push_d(1, 0, 0, 5'b10110);
    push_d(2, 1, 0, 5'b01110);

    // Small instance: pixel index p = k-1 once out of reset.
    base_s  = cyc;
    reset_s = 1'b0;
    push_s(0,  0,  0, 5'b01110);
    push_s(1,  0,  0, 5'b11110);
    push_s(11, 10, 0, 5'b10110);
    push_s(13, 12, 0, 5'b10010);
    push_s(15, 14, 0, 5'b10010);
    push_s(16, 15, 0, 5'b10110);
    push_s(17, 0,  1, 5'b11110);
    push_s(81, 0,  5, 5'b10100);
    push_s(94, 13, 5, 5'b10000);
    wait_cyc(base_s + 94);
    reset_s = 1'b1;
    @(posedge clk);
    #2;
    base_s  = cyc;
    reset_s = 1'b0;
    push_s(0,   0,  0, 5'b01110);
    push_s(1,   0,  0, 5'b11110);
    push_s(2,   1,  0, 5'b11110);
    push_s(97,  0,  6, 5'b10100);
    push_s(113, 0,  7, 5'b10110);
    push_s(128, 15, 7, 5'b10110);
    push_s(129, 0,  0, 5'b11111);
    push_s(130, 1,  0, 5'b11110);
    push_s(257, 0,  0, 5'b11111);

    for (int i = 0; i < 2000 && (q_d.size() > 0 || q_s.size() > 0); i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    chk("dflt entries left", 11'(q_d.size()), 11'd0);
    chk("small entries left", 11'(q_s.size()), 11'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
